// File: rtl/uart_program_loader.sv
// uart_program_loader
//   Packs the debug UART byte stream (big-endian, first byte = MSB) into
//   32-bit instruction words and writes them to the fetch-stage instruction
//   memory. A load starts on `start`, ends in DONE once the halt word has
//   been written, and ends in ERR on memory overflow or an inter-byte timeout.
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   start               one-cycle load request (ignored while busy)
//   rx_data, rx_done    received byte and its one-cycle valid strobe
//   wr_instruction      one-cycle write strobe to instruction memory
//   data_instruction    word being written (holds the last written value)
//   rx_address          byte address of the write, word_index*4 (holds)
//   busy                load in progress (RECV/WRITE)
//   done                one-cycle pulse after the halt word is written
//   error               high while parked in ERR
//   word_count          words written in the current or last load
module uart_program_loader #(
  parameter int          DEPTH_W        = 8,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [31:0] HALT_WORD      = 32'hFFFFFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_done,
  output logic               wr_instruction,
  output logic [31:0]        data_instruction,
  output logic [31:0]        rx_address,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [DEPTH_W:0]   word_count
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DEPTH_W:0] MAX_WORDS = {1'b1, {DEPTH_W{1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      shift_q, shift_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [DEPTH_W:0] wc_q, wc_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      addr_q, addr_d;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    gap_d      = gap_q;
    wc_d       = wc_q;
    data_d     = data_q;
    addr_d     = addr_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d    = S_RECV;
          wc_d       = '0;
          byte_cnt_d = '0;
          gap_d      = '0;
        end
      end
      S_RECV: begin
        if (rx_done) begin
          // A byte always beats a timeout expiring in the same cycle.
          shift_d = {shift_q[23:0], rx_data};
          gap_d   = '0;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = '0;
            state_d    = S_WRITE;
            data_d     = {shift_q[23:0], rx_data};
            addr_d     = 32'({wc_q, 2'b00});
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (byte_cnt_q != 2'd0) begin
          // Gap timer only runs mid-word; waiting for a word's first byte is unbounded.
          if (gap_q == GAP_LAST) state_d = S_ERR;
          else                   gap_d   = gap_q + 1'b1;
        end
      end
      S_WRITE: begin
        wc_d = wc_q + 1'b1;
        if (data_q == HALT_WORD) begin
          state_d = S_DONE;
        end else if (wc_q + 1'b1 == MAX_WORDS) begin
          state_d = S_ERR;
        end else begin
          state_d = S_RECV;
          // Keep back-to-back traffic lossless: this byte opens the next word.
          if (rx_done) begin
            shift_d    = {shift_q[23:0], rx_data};
            byte_cnt_d = 2'd1;
            gap_d      = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      gap_q      <= '0;
      wc_q       <= '0;
      data_q     <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      gap_q      <= gap_d;
      wc_q       <= wc_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
    end
  end

  assign wr_instruction   = (state_q == S_WRITE);
  assign busy             = (state_q == S_RECV) || (state_q == S_WRITE);
  assign done             = (state_q == S_DONE);
  assign error            = (state_q == S_ERR);
  assign data_instruction = data_q;
  assign rx_address       = addr_q;
  assign word_count       = wc_q;

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;
  localparam int          DW   = 2;
  localparam int          TO   = 50;
  localparam int          MAXW = 1 << DW;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wr_instruction, busy, done, error;
  logic [31:0] data_instruction, rx_address;
  logic [DW:0] word_count;

  uart_program_loader #(.DEPTH_W(DW), .TIMEOUT_CYCLES(TO), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_done(rx_done),
    .wr_instruction(wr_instruction), .data_instruction(data_instruction),
    .rx_address(rx_address), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int done_cnt = 0;
  logic [63:0] mon_q[$];   // observed writes {data, addr}
  logic [63:0] exp_q[$];   // model writes {data, addr}
  logic [31:0] prog_q[$];  // words to send

  always @(negedge clk) begin
    if (wr_instruction) mon_q.push_back({data_instruction, rx_address});
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1; step(); rx_done = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  // Sends prog_q as one load and checks it against the model.
  task automatic run_load(input int gapmax, input bit poke);
    bit exp_done, exp_err;
    int bidx;
    exp_q.delete(); exp_done = 0; exp_err = 0;
    foreach (prog_q[i]) begin
      exp_q.push_back({prog_q[i], 32'(i * 4)});
      if (prog_q[i] == HALT) begin exp_done = 1; break; end
      if (i + 1 == MAXW) begin exp_err = 1; break; end
    end
    mon_q.delete(); done_cnt = 0;
    if (poke) begin send_byte(8'hA5); send_byte(8'h5A); end
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'(1));
    bidx = 0;
    for (int w = 0; w < exp_q.size(); w++) begin
      for (int b = 0; b < 4; b++) begin
        idle($urandom_range(0, gapmax));
        if (poke && bidx == 5) start = 1'b1;
        send_byte(prog_q[w][31-8*b -: 8]);
        start = 1'b0;
        bidx++;
        if (b == 3) begin
          chk("wr_after_4th", 64'(wr_instruction), 64'(1));
          chk("wr_data", 64'(data_instruction), 64'(prog_q[w]));
          chk("wr_addr", 64'(rx_address), 64'(w * 4));
        end
      end
    end
    if (exp_done) begin
      step();
      chk("done_pulse", 64'(done), 64'(1));
      chk("busy_at_done", 64'(busy), 64'(0));
    end
    if (exp_err) begin
      step();
      chk("err_overflow", 64'(error), 64'(1));
      chk("busy_at_err", 64'(busy), 64'(0));
    end
    idle(2);
    chk("n_writes", 64'(mon_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      chk("write_entry", mon_q[i], exp_q[i]);
    chk("word_count", 64'(word_count), 64'(exp_q.size()));
    chk("done_cnt", 64'(done_cnt), 64'(exp_done));
    chk("error_end", 64'(error), 64'(exp_err));
  endtask

  initial begin
    int len;
    // Reset state
    rst = 1'b0; idle(2);
    chk("rst_wr", 64'(wr_instruction), 64'(0));
    chk("rst_data", 64'(data_instruction), 64'(0));
    chk("rst_addr", 64'(rx_address), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_wc", 64'(word_count), 64'(0));
    rst = 1'b1; step();

    // Basic program
    prog_q = '{32'h20010005, 32'h00000000, HALT};
    run_load(2, 0);

    // Back-to-back bytes: byte 0 of each next word lands in the WRITE cycle
    prog_q = '{$urandom(), $urandom(), HALT};
    run_load(0, 0);

    // Mid-word timeout
    mon_q.delete();
    pulse_start();
    send_byte(8'h12); send_byte(8'h34);
    idle(TO - 1);
    chk("to_err_early", 64'(error), 64'(0));
    chk("to_busy_early", 64'(busy), 64'(1));
    step();
    chk("to_err", 64'(error), 64'(1));
    chk("to_busy", 64'(busy), 64'(0));
    chk("to_no_write", 64'(mon_q.size()), 64'(0));
    pulse_start();
    chk("to_err_cleared", 64'(error), 64'(0));
    chk("to_restart_busy", 64'(busy), 64'(1));
    repeat (4) send_byte(8'hFF);
    idle(3);
    chk("to_recover_done", 64'(mon_q.size()), 64'(1));

    // Memory overflow: four non-halt words
    prog_q = '{$urandom() & 32'h7FFFFFFF, $urandom() & 32'h7FFFFFFF,
               $urandom() & 32'h7FFFFFFF, $urandom() & 32'h7FFFFFFF};
    run_load(1, 0);

    // IDLE bytes and a mid-load start are ignored
    prog_q = '{32'h11223344, 32'h55667788, HALT};
    run_load(1, 1);

    // Randomized programs
    for (int it = 0; it < 8; it++) begin
      prog_q.delete();
      len = $urandom_range(1, MAXW);
      for (int i = 0; i < len; i++) prog_q.push_back($urandom());
      if (len < MAXW || $urandom_range(0, 1) == 1) prog_q[len-1] = HALT;
      run_load($urandom_range(0, 3), 0);
    end

    // Reset in the cycle of the 4th byte: no write, outputs at reset values
    mon_q.delete();
    pulse_start();
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
    rx_data = 8'hEF; rx_done = 1'b1; rst = 1'b0;
    step();
    rx_done = 1'b0;
    chk("mrst_wr", 64'(wr_instruction), 64'(0));
    chk("mrst_data", 64'(data_instruction), 64'(0));
    chk("mrst_addr", 64'(rx_address), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_wc", 64'(word_count), 64'(0));
    chk("mrst_error", 64'(error), 64'(0));
    rst = 1'b1; idle(2);
    chk("mrst_no_write", 64'(mon_q.size()), 64'(0));

    // Loads work again after the abort
    prog_q = '{$urandom(), HALT};
    run_load(2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
